// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU opcodes, datapath widths
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//   req     : per-requester pending vector
//   ptr     : highest-priority index for this search
//   gnt     : one-hot selection (all zero when nothing is pending)
//   gnt_id  : binary index of the selected requester
//   gnt_any : at least one requester pending
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    always_comb begin
        int               s;
        logic [ID_W-1:0]  c;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Walk indices ptr, ptr+1, ... wrapping at NUM_REQ (which need
            // not be a power of two, so the wrap is explicit).
            s = int'(ptr) + k;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            c = ID_W'(s);
            if (!gnt_any && req[c]) begin
                gnt_any = 1'b1;
                gnt[c]  = 1'b1;
                gnt_id  = c;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters.
// A pending request is picked round-robin, its operands are latched onto the
// ALU bus, the ALU result is registered and returned on a valid/ready channel
// tagged with the requester index.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   req_valid / req_ready   : per-requester request, one-hot grant pulse
//   req_a, req_b, req_op    : packed per-requester operands and opcode
//   alu_a, alu_b, alu_op    : registered ALU bus
//   alu_result              : combinational ALU output
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id, rsp_result      : owning requester index and registered result
//
// state    | meaning
// ARB_IDLE | nothing in flight, grant any pending request
// ARB_EXEC | ALU bus holds latched operands, result captured at cycle end
// ARB_RESP | response presented; on handshake, grant the next request
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic               grant_en;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_id_d     = gnt_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        grant_en     = 1'b0;
        req_ready    = '0;

        case (state_q)
            ARB_IDLE: begin
                grant_en = 1'b1;
                if (arb_any) begin
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = gnt_id_q;
                rsp_result_d = alu_result;
                state_d      = ARB_RESP;
            end
            ARB_RESP: begin
                // The response is consumed on this edge; the next one (if
                // any) only appears after another EXEC cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    grant_en    = 1'b1;
                    state_d     = arb_any ? ARB_EXEC : ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (grant_en && arb_any) begin
            req_ready = arb_gnt;
            gnt_id_d  = arb_id;
            alu_a_d   = req_a[arb_id*DATA_W +: DATA_W];
            alu_b_d   = req_b[arb_id*DATA_W +: DATA_W];
            alu_op_d  = req_op[arb_id*OP_W +: OP_W];
            ptr_d     = (arb_id == ID_W'(NUM_REQ-1)) ? '0 : arb_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            gnt_id_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_id_q     <= gnt_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [15:0] req_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    // External ALU: 8-bit modulo ADD/SUB, anything else yields zero.
    assign alu_result = (alu_op == ALU_OP_ADD) ? alu_a + alu_b :
                        (alu_op == ALU_OP_SUB) ? alu_a - alu_b : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_op[i*4 +: 4] = op;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        #2;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d res=%h a=%h b=%h op=%h want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // One isolated request from IDLE with rsp_ready held high.
    task automatic do_one(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic [7:0] exp, input string nm);
        logic [3:0] oh;
        oh = '0; oh[i] = 1'b1;
        @(negedge clk); set_req(i, a, b, op); req_valid = oh; #1;
        total++;
        if (req_ready !== oh) begin
            bad++; $display("FAIL %s grant: got %b want %b", nm, req_ready, oh);
        end
        @(negedge clk); req_valid = '0; #1;
        total++;
        if (rsp_valid !== 1'b0 || alu_a !== a || alu_b !== b || alu_op !== op) begin
            bad++;
            $display("FAIL %s exec: vld=%b a=%h b=%h op=%h want vld=0 a=%h b=%h op=%h",
                     nm, rsp_valid, alu_a, alu_b, alu_op, a, b, op);
        end
        @(negedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== exp || rsp_id !== 2'(i)) begin
            bad++;
            $display("FAIL %s resp: vld=%b res=%h id=%0d want vld=1 res=%h id=%0d",
                     nm, rsp_valid, rsp_result, rsp_id, exp, i);
        end
        @(negedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL %s idle: vld=%b want 0", nm, rsp_valid);
        end
    endtask

    task automatic test_single_add;
        do_one(0, 8'h05, 8'h03, ALU_OP_ADD, 8'h08, "add");
    endtask

    task automatic test_wrap;
        do_one(0, 8'h03, 8'h05, ALU_OP_SUB, 8'hFE, "sub_wrap");
        do_one(0, 8'hFF, 8'h01, ALU_OP_ADD, 8'h00, "add_wrap");
        do_one(0, 8'h12, 8'h34, 4'b0010,    8'h00, "bad_op");
    endtask

    task automatic test_back_to_back;
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] res   [4] = '{8'h01, 8'h12, 8'h23, 8'h34};
        logic [3:0] oh;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_req(0, 8'h01, 8'h00, ALU_OP_ADD);
        set_req(1, 8'h11, 8'h01, ALU_OP_ADD);
        set_req(2, 8'h21, 8'h02, ALU_OP_ADD);
        set_req(3, 8'h31, 8'h03, ALU_OP_ADD);
        rsp_ready = 1'b1;
        @(negedge clk); req_valid = 4'hF; #1;
        for (int n = 0; n < 5; n++) begin
            oh = '0; oh[order[n]] = 1'b1;
            total++;
            if (req_ready !== oh) begin
                bad++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, oh);
            end
            if (n > 0) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[n-1]) ||
                    rsp_result !== res[order[n-1]]) begin
                    bad++;
                    $display("FAIL rr_resp%0d: vld=%b id=%0d res=%h want 1 %0d %h", n - 1,
                             rsp_valid, rsp_id, rsp_result, order[n-1], res[order[n-1]]);
                end
            end
            @(negedge clk); if (n == 4) req_valid = '0; #1;
            total++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_exec%0d: rdy=%b vld=%b want 0000 0", n, req_ready, rsp_valid);
            end
            @(negedge clk); #1;
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'h01 ||
            req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rr_resp4: vld=%b id=%0d res=%h rdy=%b want 1 0 01 0000",
                     rsp_valid, rsp_id, rsp_result, req_ready);
        end
    endtask

    task automatic test_backpressure;
        // Pointer is 1 after the 0,1,2,3,0 sequence.
        @(negedge clk);
        set_req(1, 8'h20, 8'h07, ALU_OP_SUB);
        set_req(2, 8'h40, 8'h02, ALU_OP_ADD);
        req_valid = 4'b0110; rsp_ready = 1'b0; #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_grant1: got %b want 0010", req_ready);
        end
        @(negedge clk); req_valid = 4'b0100; #1;
        repeat (5) begin
            @(negedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 8'h19 ||
                req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold: vld=%b id=%0d res=%h rdy=%b want 1 1 19 0000",
                         rsp_valid, rsp_id, rsp_result, req_ready);
            end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        total++;
        if (req_ready !== 4'b0100 || rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b want 0100 1", req_ready, rsp_valid);
        end
        @(negedge clk); req_valid = '0; #1;
        @(negedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 8'h42) begin
            bad++;
            $display("FAIL bp_resp2: vld=%b id=%0d res=%h want 1 2 42",
                     rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_fairness;
        do_one(2, 8'h09, 8'h04, ALU_OP_SUB, 8'h05, "fair_req2");
        @(negedge clk);
        set_req(0, 8'h30, 8'h30, ALU_OP_ADD);
        set_req(2, 8'h80, 8'h80, ALU_OP_ADD);
        req_valid = 4'b0101; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL fair_grant0: got %b want 0001", req_ready);
        end
        @(negedge clk); req_valid = 4'b0100; #1;
        @(negedge clk); #1;
        total++;
        if (rsp_id !== 2'd0 || rsp_result !== 8'h60 || req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL fair_grant2: id=%0d res=%h rdy=%b want 0 60 0100",
                     rsp_id, rsp_result, req_ready);
        end
        @(negedge clk); req_valid = '0; #1;
        @(negedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 8'h00) begin
            bad++;
            $display("FAIL fair_resp2: vld=%b id=%0d res=%h want 1 2 00",
                     rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); #1;   // back in IDLE, pointer at 3
        @(negedge clk); set_req(0, 8'hAA, 8'h11, ALU_OP_ADD); req_valid = 4'b0001; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rmid_grant: got %b want 0001", req_ready);
        end
        @(negedge clk); req_valid = '0; rst_n = 1'b0; #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op} !== '0) begin
            bad++;
            $display("FAIL rmid_clear: rdy=%b vld=%b id=%0d res=%h a=%h b=%h op=%h want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            total++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL rmid_quiet: vld=%b rdy=%b want 0 0000", rsp_valid, req_ready);
            end
        end
        @(negedge clk); req_valid = 4'hF; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rmid_ptr: got %b want 0001", req_ready);
        end
        @(negedge clk); req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
